// File: rtl/dphy_hs_rx_sequencer.sv
// dphy_hs_rx_sequencer
// Per-link D-PHY receive sequencer. Synchronizes and filters the LP line
// pair, walks the HS-entry sequence LP-11 -> LP-01 -> LP-00 -> settle -> HS,
// gates the HS datapath for each burst and detects burst end on LP-11.
// A burst timeout forces an exit from a stuck burst and raises a sticky
// error flag; burst_count keeps a wrapping tally of completed bursts.
//
// Optional build macro: DPHY_SEQ_ESC_DETECT_EN
//   When defined, LP-10 seen in STOP enters ESCAPE (HS path kept off) until
//   LP-11 returns, and a sticky esc_seen output (cleared by err_clear) is
//   added. When undefined, LP-10 in STOP is ignored and esc_seen is absent.
module dphy_hs_rx_sequencer #(
    parameter int LP_FILTER     = 4,
    parameter int SETTLE_CYCLES = 24,
    parameter int HS_TIMEOUT    = 32768
) (
    input  logic        dphy_clk,
    input  logic        areset,
    input  logic        enable,
    input  logic        lp_p,
    input  logic        lp_n,
    input  logic        err_clear,
    output logic        hs_term_en,
    output logic        rx_active,
    output logic        aligner_reset,
    output logic        burst_start,
    output logic        burst_end,
    output logic        timeout_err,
    output logic [15:0] burst_count,
    output logic [2:0]  state
`ifdef DPHY_SEQ_ESC_DETECT_EN
    ,
    output logic        esc_seen
`endif
);

    // State encodings are part of the debug interface; keep them stable.
    localparam logic [2:0] S_DISABLED = 3'd0;
    localparam logic [2:0] S_STOP     = 3'd1;
    localparam logic [2:0] S_HS_RQST  = 3'd2;
    localparam logic [2:0] S_HS_PREP  = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_ACTIVE   = 3'd5;
    localparam logic [2:0] S_ESCAPE   = 3'd6;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_10 = 2'b10;

    localparam logic [3:0]  FILTER_LEN  = 4'(LP_FILTER);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(HS_TIMEOUT - 1);

    // ---------------------------------------------------------------------
    // LP input synchronizer and glitch filter
    // ---------------------------------------------------------------------
    logic [1:0] lp_raw;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] lp_prev_reg;
    logic [3:0] run_reg;
    logic [3:0] run_next;
    logic [1:0] lp_f_reg;

    assign lp_raw = {lp_p, lp_n};

    // Length of the current run of identical synced samples, this one included.
    always_comb begin
        run_next = 4'd1;
        if (sync2_reg == lp_prev_reg) begin
            if (run_reg == 4'hF) begin
                run_next = 4'hF;
            end else begin
                run_next = run_reg + 4'd1;
            end
        end
    end

    // Two-flop synchronizer feeding a run-length filter; lp_f only moves to a
    // code that has been stable for LP_FILTER consecutive synced samples.
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            sync1_reg   <= LP_11;
            sync2_reg   <= LP_11;
            lp_prev_reg <= LP_11;
            run_reg     <= 4'd0;
            lp_f_reg    <= LP_11;
        end else begin
            sync1_reg   <= lp_raw;
            sync2_reg   <= sync1_reg;
            lp_prev_reg <= sync2_reg;
            run_reg     <= run_next;
            if ((sync2_reg != lp_f_reg) && (run_next >= FILTER_LEN)) begin
                lp_f_reg <= sync2_reg;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [7:0]  settle_reg;
    logic [7:0]  settle_next;
    logic [15:0] timeout_cnt_reg;
    logic [15:0] timeout_cnt_next;
    logic        timeout_hit;
    logic        leave_active;
    logic        enter_active;
    logic        enter_escape;

    // Next-state decode; disable overrides everything, and in ACTIVE the
    // LP-11 check sits ahead of the timeout so a real end of burst wins.
    always_comb begin
        state_next       = state_reg;
        settle_next      = settle_reg;
        timeout_cnt_next = timeout_cnt_reg;
        timeout_hit      = 1'b0;
        if (!enable) begin
            state_next = S_DISABLED;
        end else begin
            case (state_reg)
                S_DISABLED: begin
                    if (lp_f_reg == LP_11) begin
                        state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    if (lp_f_reg == LP_01) begin
                        state_next = S_HS_RQST;
                    end
`ifdef DPHY_SEQ_ESC_DETECT_EN
                    else if (lp_f_reg == LP_10) begin
                        state_next = S_ESCAPE;
                    end
`endif
                end
                S_HS_RQST: begin
                    if (lp_f_reg == LP_00) begin
                        state_next = S_HS_PREP;
                    end else if (lp_f_reg != LP_01) begin
                        state_next = S_STOP;
                    end
                end
                S_HS_PREP: begin
                    state_next  = S_SETTLE;
                    settle_next = 8'd0;
                end
                S_SETTLE: begin
                    if (lp_f_reg == LP_11) begin
                        state_next = S_STOP;
                    end else if (settle_reg == SETTLE_LAST) begin
                        state_next       = S_ACTIVE;
                        timeout_cnt_next = 16'd0;
                    end else begin
                        settle_next = settle_reg + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (lp_f_reg == LP_11) begin
                        state_next = S_STOP;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        state_next  = S_STOP;
                        timeout_hit = 1'b1;
                    end else begin
                        timeout_cnt_next = timeout_cnt_reg + 16'd1;
                    end
                end
                S_ESCAPE: begin
`ifdef DPHY_SEQ_ESC_DETECT_EN
                    if (lp_f_reg == LP_11) begin
                        state_next = S_STOP;
                    end
`else
                    state_next = S_STOP;
`endif
                end
                default: begin
                    state_next = S_DISABLED;
                end
            endcase
        end
    end

    assign leave_active = (state_reg == S_ACTIVE) && (state_next != S_ACTIVE);
    assign enter_active = (state_reg != S_ACTIVE) && (state_next == S_ACTIVE);
    assign enter_escape = (state_reg != S_ESCAPE) && (state_next == S_ESCAPE);

    // State and phase counters.
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state_reg       <= S_DISABLED;
            settle_reg      <= 8'd0;
            timeout_cnt_reg <= 16'd0;
        end else begin
            state_reg       <= state_next;
            settle_reg      <= settle_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they line up with
    // the state register and never glitch.
    // ---------------------------------------------------------------------
    logic        hs_term_en_reg;
    logic        rx_active_reg;
    logic        burst_start_reg;
    logic        burst_end_reg;
    logic        timeout_err_reg;
    logic [15:0] burst_count_reg;

    // Datapath gating, burst pulses, statistics and the sticky timeout flag
    // (a timeout in the same cycle as err_clear leaves the flag set).
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            hs_term_en_reg  <= 1'b0;
            rx_active_reg   <= 1'b0;
            burst_start_reg <= 1'b0;
            burst_end_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            burst_count_reg <= 16'd0;
        end else begin
            hs_term_en_reg  <= (state_next == S_HS_PREP) ||
                               (state_next == S_SETTLE)  ||
                               (state_next == S_ACTIVE);
            rx_active_reg   <= (state_next == S_ACTIVE);
            burst_start_reg <= enter_active;
            burst_end_reg   <= leave_active;
            if (leave_active) begin
                burst_count_reg <= burst_count_reg + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clear) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

`ifdef DPHY_SEQ_ESC_DETECT_EN
    logic esc_seen_reg;

    // Sticky escape-entry flag; a new entry beats a simultaneous clear.
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            esc_seen_reg <= 1'b0;
        end else if (enter_escape) begin
            esc_seen_reg <= 1'b1;
        end else if (err_clear) begin
            esc_seen_reg <= 1'b0;
        end
    end

    assign esc_seen = esc_seen_reg;
`else
    logic unused_escape;
    assign unused_escape = enter_escape;
`endif

    assign hs_term_en    = hs_term_en_reg;
    assign rx_active     = rx_active_reg;
    assign aligner_reset = !rx_active_reg;
    assign burst_start   = burst_start_reg;
    assign burst_end     = burst_end_reg;
    assign timeout_err   = timeout_err_reg;
    assign burst_count   = burst_count_reg;
    assign state         = state_reg;

endmodule
